// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : LoongArch control/status register file. It serves CSR read/write,
//            exception and ertn commits from WB, and provides the redirect
//            targets and the pending-interrupt flag. The stable timer
//            (TID/TCFG/TVAL/TICLR, ESTAT.IS[11]) is built only when
//            CSR_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [79:0] csr_ctrl,
    input  logic        wb_ex,
    input  logic        ertn_flush,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [7:0]  hw_int_in,
    output logic [31:0] csr_rvalue,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);

    localparam logic [13:0] c_CSR_CRMD   = 14'h000;
    localparam logic [13:0] c_CSR_PRMD   = 14'h001;
    localparam logic [13:0] c_CSR_ECFG   = 14'h004;
    localparam logic [13:0] c_CSR_ESTAT  = 14'h005;
    localparam logic [13:0] c_CSR_ERA    = 14'h006;
    localparam logic [13:0] c_CSR_BADV   = 14'h007;
    localparam logic [13:0] c_CSR_EENTRY = 14'h00C;
    localparam logic [13:0] c_CSR_SAVE0  = 14'h030;
    localparam logic [13:0] c_CSR_SAVE1  = 14'h031;
    localparam logic [13:0] c_CSR_SAVE2  = 14'h032;
    localparam logic [13:0] c_CSR_SAVE3  = 14'h033;
`ifdef CSR_TIMER_EN
    localparam logic [13:0] c_CSR_TID    = 14'h040;
    localparam logic [13:0] c_CSR_TCFG   = 14'h041;
    localparam logic [13:0] c_CSR_TVAL   = 14'h042;
    localparam logic [13:0] c_CSR_TICLR  = 14'h044;
`endif

    localparam logic [31:0] c_MASK_CRMD   = 32'h0000_000F;
    localparam logic [31:0] c_MASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] c_MASK_ECFG   = 32'h0000_1BFF;
    localparam logic [31:0] c_MASK_ALL    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_MASK_EENTRY = 32'hFFFF_FFC0;

    localparam logic [5:0]  c_ECODE_ADE  = 6'h08;
    localparam logic [5:0]  c_ECODE_ALE  = 6'h09;

    logic        w_we;
    logic [13:0] w_num;
    logic [31:0] w_wmask;
    logic [31:0] w_wvalue;
    logic        w_unused_re;

    assign w_unused_re = csr_ctrl[79];
    assign w_we        = csr_ctrl[78];
    assign w_num       = csr_ctrl[77:64];
    assign w_wmask     = csr_ctrl[63:32];
    assign w_wvalue    = csr_ctrl[31:0];

    // Registers keep unimplemented bits at zero, so merging inside fmask only
    // is enough to make them read back as zero.
    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [31:0] wmask,
                                            input logic [31:0] wval,
                                            input logic [31:0] fmask);
        f_merge = (old & ~(wmask & fmask)) | (wval & wmask & fmask);
    endfunction

    logic [31:0] r_crmd;
    logic [31:0] r_prmd;
    logic [31:0] r_ecfg;
    logic [1:0]  r_estat_sw;
    logic [7:0]  r_estat_hw;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic [31:0] r_era;
    logic [31:0] r_badv;
    logic [31:0] r_eentry;
    logic [31:0] r_save0;
    logic [31:0] r_save1;
    logic [31:0] r_save2;
    logic [31:0] r_save3;
    logic        w_estat_ti;
    logic [11:0] w_is;

    // Commit order inside the block sets priority: csr write, then ertn,
    // then exception, so later assignments override overlapping fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_crmd     <= 32'h0000_0008;
            r_prmd     <= '0;
            r_ecfg     <= '0;
            r_estat_sw <= '0;
            r_estat_hw <= '0;
            r_ecode    <= '0;
            r_esubcode <= '0;
            r_era      <= '0;
            r_badv     <= '0;
            r_eentry   <= '0;
            r_save0    <= '0;
            r_save1    <= '0;
            r_save2    <= '0;
            r_save3    <= '0;
        end else begin
            r_estat_hw <= hw_int_in;
            if (w_we) begin
                case (w_num)
                    c_CSR_CRMD:   r_crmd   <= f_merge(r_crmd, w_wmask, w_wvalue, c_MASK_CRMD);
                    c_CSR_PRMD:   r_prmd   <= f_merge(r_prmd, w_wmask, w_wvalue, c_MASK_PRMD);
                    c_CSR_ECFG:   r_ecfg   <= f_merge(r_ecfg, w_wmask, w_wvalue, c_MASK_ECFG);
                    c_CSR_ESTAT:  r_estat_sw <= (r_estat_sw & ~w_wmask[1:0])
                                              | (w_wvalue[1:0] & w_wmask[1:0]);
                    c_CSR_ERA:    r_era    <= f_merge(r_era, w_wmask, w_wvalue, c_MASK_ALL);
                    c_CSR_BADV:   r_badv   <= f_merge(r_badv, w_wmask, w_wvalue, c_MASK_ALL);
                    c_CSR_EENTRY: r_eentry <= f_merge(r_eentry, w_wmask, w_wvalue, c_MASK_EENTRY);
                    c_CSR_SAVE0:  r_save0  <= f_merge(r_save0, w_wmask, w_wvalue, c_MASK_ALL);
                    c_CSR_SAVE1:  r_save1  <= f_merge(r_save1, w_wmask, w_wvalue, c_MASK_ALL);
                    c_CSR_SAVE2:  r_save2  <= f_merge(r_save2, w_wmask, w_wvalue, c_MASK_ALL);
                    c_CSR_SAVE3:  r_save3  <= f_merge(r_save3, w_wmask, w_wvalue, c_MASK_ALL);
                    default: ;
                endcase
            end
            if (ertn_flush) begin
                r_crmd[2:0] <= r_prmd[2:0];
            end
            if (wb_ex) begin
                r_prmd[2:0] <= r_crmd[2:0];
                r_crmd[2:0] <= 3'b000;
                r_ecode     <= wb_ecode;
                r_esubcode  <= wb_esubcode;
                r_era       <= wb_pc;
                if (wb_ecode == c_ECODE_ADE && wb_esubcode == 9'd0) begin
                    r_badv <= wb_pc;
                end else if ((wb_ecode == c_ECODE_ADE && wb_esubcode == 9'd1) ||
                             wb_ecode == c_ECODE_ALE) begin
                    r_badv <= wb_vaddr;
                end
            end
        end
    end

`ifdef CSR_TIMER_EN
    logic [31:0]        r_tid;
    logic [TIMER_W-1:0] r_tcfg;
    logic [TIMER_W-1:0] r_tval;
    logic               r_timer_is;
    logic [TIMER_W-1:0] w_tcfg_wr;
    logic               w_wr_tcfg;
    logic [TIMER_W-1:0] w_reload;

    assign w_wr_tcfg  = w_we && (w_num == c_CSR_TCFG);
    assign w_tcfg_wr  = (r_tcfg & ~w_wmask[TIMER_W-1:0])
                      | (w_wvalue[TIMER_W-1:0] & w_wmask[TIMER_W-1:0]);
    assign w_reload   = {r_tcfg[TIMER_W-1:2], 2'b00};
    assign w_estat_ti = r_timer_is;

    // The set on expiry is written after the TICLR clear so that it wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tid      <= '0;
            r_tcfg     <= '0;
            r_tval     <= '0;
            r_timer_is <= 1'b0;
        end else begin
            if (w_we && w_num == c_CSR_TID) begin
                r_tid <= f_merge(r_tid, w_wmask, w_wvalue, c_MASK_ALL);
            end
            if (w_wr_tcfg) begin
                r_tcfg <= w_tcfg_wr;
            end
            if (w_we && w_num == c_CSR_TICLR && w_wmask[0] && w_wvalue[0]) begin
                r_timer_is <= 1'b0;
            end
            if (w_wr_tcfg && w_tcfg_wr[0]) begin
                r_tval <= {w_tcfg_wr[TIMER_W-1:2], 2'b00};
            end else if (r_tcfg[0] && r_tval != '0) begin
                if (r_tval == TIMER_W'(1)) begin
                    r_timer_is <= 1'b1;
                    r_tval     <= r_tcfg[1] ? w_reload : '0;
                end else begin
                    r_tval <= r_tval - TIMER_W'(1);
                end
            end
        end
    end
`else
    logic [TIMER_W-1:0] w_unused_timer;
    assign w_unused_timer = '0;
    assign w_estat_ti     = 1'b0;
`endif

    assign w_is = {w_estat_ti, 1'b0, r_estat_hw, r_estat_sw};

    always_comb begin
        csr_rvalue = '0;
        case (w_num)
            c_CSR_CRMD:   csr_rvalue = r_crmd;
            c_CSR_PRMD:   csr_rvalue = r_prmd;
            c_CSR_ECFG:   csr_rvalue = r_ecfg;
            c_CSR_ESTAT:  csr_rvalue = {1'b0, r_esubcode, r_ecode, 4'b0000, w_is};
            c_CSR_ERA:    csr_rvalue = r_era;
            c_CSR_BADV:   csr_rvalue = r_badv;
            c_CSR_EENTRY: csr_rvalue = r_eentry;
            c_CSR_SAVE0:  csr_rvalue = r_save0;
            c_CSR_SAVE1:  csr_rvalue = r_save1;
            c_CSR_SAVE2:  csr_rvalue = r_save2;
            c_CSR_SAVE3:  csr_rvalue = r_save3;
`ifdef CSR_TIMER_EN
            c_CSR_TID:    csr_rvalue = r_tid;
            c_CSR_TCFG:   csr_rvalue = 32'(r_tcfg);
            c_CSR_TVAL:   csr_rvalue = 32'(r_tval);
`endif
            default:      csr_rvalue = '0;
        endcase
    end

    assign ex_entry   = r_eentry;
    assign ertn_entry = r_era;
    assign has_int    = (|({1'b0, w_is} & r_ecfg[12:0])) & r_crmd[2];

endmodule
`default_nettype wire
